// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/multu/div/divu
// with a fixed busy window, and handles mthi/mtlo writes while idle.
//
// state | meaning
// IDLE  | no operation in flight; accepts start, mthi and mtlo
// RUN   | result held in shadow regs; counter runs down to the commit cycle
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = MULT_CYCLES[3:0];
    localparam logic [3:0] DIV_LOAD  = DIV_CYCLES[3:0];

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state;
    logic [3:0]  count;
    logic [31:0] shadow_hi;
    logic [31:0] shadow_lo;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        div_zero;
    logic [63:0] result;
    logic        op_valid;
    logic [3:0]  load_val;

    always_comb begin
        prod_s   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        prod_u   = {32'b0, src_a} * {32'b0, src_b};
        div_zero = (src_b == 32'd0);

        // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
        mag_a = src_a[31] ? (32'd0 - src_a) : src_a;
        mag_b = src_b[31] ? (32'd0 - src_b) : src_b;
        q_mag = div_zero ? 32'd0 : (mag_a / mag_b);
        r_mag = div_zero ? 32'd0 : (mag_a % mag_b);
        q_s   = (src_a[31] ^ src_b[31]) ? (32'd0 - q_mag) : q_mag;
        r_s   = src_a[31] ? (32'd0 - r_mag) : r_mag;
        q_u   = div_zero ? 32'd0 : (src_a / src_b);
        r_u   = div_zero ? 32'd0 : (src_a % src_b);

        result = {hi, lo};
        case (md_op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = div_zero ? {hi, lo} : {r_s, q_s};
            OP_DIVU:  result = div_zero ? {hi, lo} : {r_u, q_u};
            default:  result = {hi, lo};
        endcase

        op_valid = start && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
        load_val = ((md_op == OP_MULT) || (md_op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            busy      <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            shadow_hi <= 32'd0;
            shadow_lo <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        shadow_hi <= result[63:32];
                        shadow_lo <= result[31:0];
                        count     <= load_val;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else if (!start && (md_op == OP_MTHI)) begin
                        hi <= src_a;
                    end else if (!start && (md_op == OP_MTLO)) begin
                        lo <= src_a;
                    end
                end
                RUN: begin
                    if (count <= 4'd1) begin
                        hi    <= shadow_hi;
                        lo    <= shadow_lo;
                        count <= 4'd0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus random traffic against a cycle-level
// reference model that tracks HI/LO and the remaining busy window.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    int          rem  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] ch,
                                               input logic [31:0] cl);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              q, r;
        logic [63:0]     res;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'(a);
        ub = longint'(b);
        res = {ch, cl};
        case (op)
            3'd1: res = 64'(sa * sb);
            3'd2: res = 64'(ua * ub);
            3'd3: begin
                if (b == 32'd0) res = {ch, cl};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
                else begin
                    q = int'(a) / int'(b);
                    r = int'(a) % int'(b);
                    res = {32'(r), 32'(q)};
                end
            end
            3'd4: begin
                if (b == 32'd0) res = {ch, cl};
                else res = {32'(ua % ub), 32'(ua / ub)};
            end
            default: res = {ch, cl};
        endcase
        return res;
    endfunction

    task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("busy", {31'd0, busy}, {31'd0, (rem > 0)});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        start = s;
        md_op = op;
        src_a = a;
        src_b = b;
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (s && op >= 3'd1 && op <= 3'd4) begin
            {p_hi, p_lo} = ref_result(op, a, b, m_hi, m_lo);
            rem = (op <= 3'd2) ? MC : DC;
        end else if (!s && op == 3'd5) begin
            m_hi = a;
        end else if (!s && op == 3'd6) begin
            m_lo = a;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    initial begin
        logic [31:0] a, b;
        reset = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b1;
        @(posedge clk);

        step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
        idle(MC + 1);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        step(1'b1, 3'd2, 32'hFFFF_FFFE, 32'd3);
        idle(MC + 1);
        check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        step(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
        idle(DC + 1);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        step(1'b0, 3'd5, 32'h11, 32'd0);
        step(1'b0, 3'd6, 32'h22, 32'd0);
        step(1'b1, 3'd4, 32'd5, 32'd0);
        idle(DC + 1);
        check_hilo("divu0", 32'h11, 32'h22);

        step(1'b1, 3'd1, 32'd7, 32'd6);
        idle(1);
        step(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(MC - 1);
        check_hilo("ignstart", 32'd0, 32'd42);

        step(1'b0, 3'd6, 32'h55, 32'd0);
        check_hilo("mtlo", 32'd0, 32'h55);

        step(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC + 1);
        check_hilo("divovf", 32'd0, 32'h8000_0000);

        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), a, b);
        end
        idle(DC + 1);

        step(1'b0, 3'd5, 32'hDEAD_BEEF, 32'd0);
        step(1'b1, 3'd1, 32'd7, 32'd6);
        idle(2);
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        rem  = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        start = 1'b0;
        md_op = 3'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        idle(MC + 2);
        check_hilo("post_rst", 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the five-stage MIPS pipeline.
- Executes mult, multu, div, divu, mthi and mtlo. Holds the architectural HI/LO registers and returns their contents for mfhi/mflo.
- Its start and busy outputs feed the hazard unit directly. The hazard unit stalls F/D and flushes E whenever a multiply/divide-class instruction sits in D while start or busy is high.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, number of busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse from E-stage decode when a mult/multu/div/divu is in E; already gated by the hazard unit's flush_E.
- md_op  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is reserved and treated as none.
- src_a  input  32  forwarded rs value (E stage).
- src_b  input  32  forwarded rt value (E stage).
- busy  output  1  high while a multiply or divide is in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (reset=0, asynchronous): busy=0, hi=0, lo=0, counter=0, shadow registers=0, state=IDLE. This is immediate and overrides any operation in flight; a partial result is discarded.
- States: IDLE, RUN.
- IDLE + start=1 + md_op in {1,2,3,4}:
  - compute the result combinationally from src_a/src_b;
  - capture it into shadow_hi/shadow_lo;
  - load the counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4);
  - go to RUN.
- start=1 with md_op outside {1..4}: ignored.
- RUN: the counter decrements each cycle. The cycle it reaches 1 commits the shadow registers to hi/lo, clears busy and returns to IDLE.
- Latency for a start in cycle T:
  - busy is high in cycles T+1 .. T+N;
  - hi/lo hold their old values through T+N;
  - the new values are visible in cycle T+N+1, when busy is back at 0.
- start has no effect on busy in cycle T itself. The hazard unit uses start|busy.
- mult: signed 32x32 to 64-bit product. hi = product[63:32], lo = product[31:0].
- multu: the same with unsigned operands.
- div: signed division. lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend (src_a).
- divu: unsigned division. lo = quotient, hi = remainder.
- Divide by zero (src_b=0, div or divu): the unit still goes busy for DIV_CYCLES, then commits hi and lo unchanged (the shadow registers are loaded with the current hi/lo).
- Signed overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- mthi (md_op=5) and mtlo (md_op=6) are decoded with start=0:
  - in IDLE, write src_a into hi (or lo) at the clock edge ending that cycle; the new value is visible next cycle;
  - in RUN, they are ignored, because the hazard unit never lets one reach E while busy.
- start while in RUN is ignored and does not restart the counter.
- The hi and lo outputs are always the committed registers. The mfhi/mflo mux lives in the E-stage datapath, outside this block.
- A flush of E does not cancel an in-flight operation. Only reset does.

Test Plan:
- Reset mid-RUN: start mult (src_a=7, src_b=6), then pull reset low in cycle T+3 -> busy=0, hi=0, lo=0 immediately. After reset is released, busy stays 0 and hi/lo stay 0.
- Signed mult: src_a=0xFFFFFFFE (-2), src_b=3, md_op=1 at T -> busy=1 for T+1..T+5; at T+6, hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- multu on the same operands -> at T+6, hi=0x00000002, lo=0xFFFFFFFA.
- Signed div: src_a=-7 (0xFFFFFFF9), src_b=2, md_op=3 -> busy for 10 cycles; at T+11, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu by zero with hi=0x11, lo=0x22 preloaded via mthi/mtlo -> busy for 10 cycles, after which hi=0x11 and lo=0x22.
- Ignored start: a second start with md_op=2 in cycle T+2 of a running mult -> busy still falls after T+5 and the first mult's result is committed. Also: an mtlo with src_a=0x55 issued in IDLE -> lo=0x55 in the next cycle.
